div_unit: RTL and testbench
===========================

// Module: div_unit
// PURPOSE
//  Multi-cycle iterative divider for DIV/DIVU, instantiated in the EX stage.
//  Quotient feeds lo_wdata and remainder feeds hi_wdata; both travel EX->MEM->WB to the hi/lo register pair.
//  The decoder generates hi_we/lo_we, not this block.
//  Holds the pipeline via stallreq until the result is ready. Radix-2 restoring: one quotient bit per cycle.
// PARAMETERS
//  WIDTH  32  operand/result width; iteration count equals WIDTH
// PORTS
//  clk          in   1      pipeline clock; single clock domain
//  rst          in   1      synchronous, active-high reset
//  annul        in   1      flush of the EX instruction; cancels any operation
//  start        in   1      level; high while a DIV/DIVU sits in EX
//  signed_div   in   1      1 = DIV (two's complement), 0 = DIVU
//  dividend     in   WIDTH  rs operand, sampled only on accept
//  divisor      in   WIDTH  rt operand, sampled only on accept
//  ack          in   1      EX advanced and consumed the result (pulse)
//  result_ready out  1      quotient/remainder valid
//  quotient     out  WIDTH  to lo_wdata path
//  remainder    out  WIDTH  to hi_wdata path
//  stallreq     out  1      to stall controller; freezes IF..EX
// BEHAVIOUR
//  Reset: state=IDLE; result_ready=0; quotient=0; remainder=0; count=0; stallreq forced 0 while rst=1.
//  Priority each edge: rst > annul > FSM. annul in any state -> IDLE, result_ready=0, outputs keep old value.
//  FSM states (encodings in defines.vh): IDLE, BUSY, DONE.
//   IDLE: start=1 and divisor!=0 -> latch |dividend|, |divisor| (abs only when signed_div), signs, signed_div;
//         rem=0, count=0 -> BUSY.
//   IDLE: start=1 and divisor==0 -> DONE next edge; quotient={WIDTH{1}}; remainder=dividend (raw).
//   BUSY: per edge {rem,q}<<=1; trial=rem-dvs (WIDTH+1 bits); if trial>=0 rem=trial, q[0]=1; count++.
//   BUSY at count==WIDTH-1: final step done -> DONE. Quotient and remainder are registered with sign fix-up.
//   DONE: result_ready=1, outputs stable; ack=1 -> IDLE (result_ready=0 next cycle).
//  Sign fix-up (signed only): quotient negated iff sign(dividend)^sign(divisor).
//   Remainder takes the dividend's sign. Results are truncated toward zero.
//   Corner: 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0 (wraps, no trap).
//  Latency: accept edge -> WIDTH BUSY cycles -> result_ready high WIDTH+1 cycles after accept (33 at WIDTH=32).
//   Divide-by-zero: 1 cycle after accept.
//  stallreq = ~rst & ~annul & start & (state!=DONE). It is high in IDLE with start, and through all of BUSY.
//   It drops combinationally in the DONE cycle so EX can advance.
//  Operand changes during BUSY/DONE are ignored (latched copies are used).
//  start falling during BUSY without annul: the operation completes and waits in DONE for ack.
//  ack outside DONE: ignored. start and ack both high in DONE -> IDLE; a new op is accepted no earlier than the next edge.
//  Back-to-back divides: second accepted the cycle after ack, so there is no result aliasing.
//  annul together with start in IDLE: annul wins, nothing is accepted.
// STRUCTURE
//  lib/defines.vh: `DivFree/`DivBusy/`DivEnd state codes, `DivCntBus width, `DivResultBus (2*WIDTH packed {rem,quot}).
//  Sub-module div_step: combinational single restoring iteration (rem_in, q_in, dvs -> rem_out, q_out).
//  Everything else (FSM, counter, abs/negate, output regs) stays in div_unit; no other hierarchy.
// TESTING
//  DIVU 100/7: start=1 -> stallreq=1 for 33 cycles; result_ready at cycle 33; q=14, r=2; ack -> IDLE.
//  DIV -7/2 (0xFFFFFFF9/0x2) -> q=0xFFFFFFFD, r=0xFFFFFFFF; DIV 7/-2 -> q=0xFFFFFFFD, r=1.
//  DIV 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0; DIVU 0xFFFFFFFF/1 -> q=0xFFFFFFFF, r=0.
//  Divisor 0, dividend 0x1234 -> result_ready after 1 cycle; q=0xFFFFFFFF, r=0x1234.
//  annul at BUSY count=10 -> IDLE next cycle, result_ready stays 0; new DIVU 9/3 then -> q=3, r=0 at 33 cycles.
//  rst asserted mid-BUSY -> all outputs 0, stallreq 0; back-to-back DIVU with ack -> two correct results, no overlap.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared width defaults and FSM state codes for the iterative divider.
package div_unit_pkg;

  localparam int unsigned DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_unit_if.sv
// EX-stage <-> divider handshake: operands and control in, result and stall out.
interface div_unit_if import div_unit_pkg::*; #(
  parameter int unsigned WIDTH = DIV_WIDTH
);

  logic             annul;
  logic             start;
  logic             signed_div;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             ack;
  logic             result_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             stallreq;

  modport master (
    output annul, start, signed_div, dividend, divisor, ack,
    input  result_ready, quotient, remainder, stallreq
  );

  modport slave (
    input  annul, start, signed_div, dividend, divisor, ack,
    output result_ready, quotient, remainder, stallreq
  );

endinterface

// File: rtl/div_unit_step.sv
// One radix-2 restoring iteration: shift {rem,q} left, subtract divisor, keep if non-negative.
module div_unit_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  assign shifted = {rem_i, q_i[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_i};

  // trial MSB set means the subtraction went negative: restore
  assign rem_o = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign q_o   = {q_i[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit for the EX stage; holds the pipeline via stallreq until done.
module div_unit import div_unit_pkg::*; #(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  div_unit_if.slave   bus
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] dvs_q;
  logic             neg_quot_q;
  logic             neg_rem_q;
  logic [WIDTH-1:0] quot_out_q;
  logic [WIDTH-1:0] rem_out_q;
  logic             ready_q;

  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dvs_abs;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_q;
  logic [WIDTH-1:0] quot_d;
  logic [WIDTH-1:0] rem_d;

  // Magnitudes and signs of the operands, valid only in the accept cycle
  assign dvd_neg = bus.signed_div & bus.dividend[WIDTH-1];
  assign dvs_neg = bus.signed_div & bus.divisor[WIDTH-1];
  assign dvd_abs = dvd_neg ? -bus.dividend : bus.dividend;
  assign dvs_abs = dvs_neg ? -bus.divisor  : bus.divisor;

  div_unit_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .q_i   (q_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  // Sign fix-up on the final step; remainder follows the dividend's sign
  assign quot_d = neg_quot_q ? -step_q   : step_q;
  assign rem_d  = neg_rem_q  ? -step_rem : step_rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      q_q        <= '0;
      dvs_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      quot_out_q <= '0;
      rem_out_q  <= '0;
      ready_q    <= 1'b0;
    end else if (bus.annul) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            if (bus.divisor == '0) begin
              quot_out_q <= '1;
              rem_out_q  <= bus.dividend;
              ready_q    <= 1'b1;
              state_q    <= ST_DONE;
            end else begin
              rem_q      <= '0;
              q_q        <= dvd_abs;
              dvs_q      <= dvs_abs;
              neg_quot_q <= dvd_neg ^ dvs_neg;
              neg_rem_q  <= dvd_neg;
              cnt_q      <= '0;
              state_q    <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          rem_q <= step_rem;
          q_q   <= step_q;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            quot_out_q <= quot_d;
            rem_out_q  <= rem_d;
            ready_q    <= 1'b1;
            state_q    <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.ack) begin
            ready_q <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Combinational so EX can advance in the very cycle the result is presented
  assign bus.stallreq     = ~rst & ~bus.annul & bus.start & (state_q != ST_DONE);
  assign bus.result_ready = ready_q;
  assign bus.quotient     = quot_out_q;
  assign bus.remainder    = rem_out_q;

endmodule

// File: tb/tb_div_unit.sv
// Randomized and directed bench for div_unit against a timing/arithmetic reference model.
module tb_div_unit;

  localparam int unsigned W   = 32;
  localparam int          LAT = 33;

  logic clk;
  logic rst;

  div_unit_if #(.WIDTH(W)) bus ();

  div_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Reference model state: what the outputs must be after each edge
  logic          m_ready = 1'b0;
  logic [W-1:0]  m_q = '0;
  logic [W-1:0]  m_r = '0;
  logic [W-1:0]  p_q = '0;
  logic [W-1:0]  p_r = '0;
  bit            m_busy = 1'b0;
  int            m_left = 0;

  function automatic void check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void ref_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
    longint sa, sb;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ready = 1'b0; m_q = '0; m_r = '0; m_busy = 1'b0; m_left = 0;
    end else if (bus.annul) begin
      m_busy  = 1'b0;
      m_ready = 1'b0;
    end else if (m_ready) begin
      if (bus.ack) m_ready = 1'b0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0; m_ready = 1'b1; m_q = p_q; m_r = p_r;
      end
    end else if (bus.start) begin
      ref_div(bus.signed_div, bus.dividend, bus.divisor, p_q, p_r);
      if (bus.divisor == '0) begin
        m_ready = 1'b1; m_q = p_q; m_r = p_r;
      end else begin
        m_busy = 1'b1; m_left = LAT - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready",    W'(bus.result_ready), W'(m_ready));
      check("stallreq", W'(bus.stallreq), W'(!rst && !bus.annul && bus.start && !m_ready));
      check("quotient", bus.quotient, m_q);
      check("remainder", bus.remainder, m_r);
    end
  end

  task automatic drive_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1; bus.signed_div = sgn; bus.dividend = a; bus.divisor = b;
  endtask

  task automatic wait_ready(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      bus.dividend = $urandom;
      bus.divisor  = $urandom;
    end while (!bus.result_ready && lat < 100);
  endtask

  task automatic do_div(input string name, input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input int elat);
    int lat;
    @(posedge clk); #1;
    drive_op(sgn, a, b);
    bus.ack = 1'b0;
    #1;
    check({name, "_stall_start"}, W'(bus.stallreq), W'(1));
    wait_ready(lat);
    check({name, "_latency"}, W'(lat), W'(elat));
    check({name, "_q"}, bus.quotient, eq);
    check({name, "_r"}, bus.remainder, er);
    check({name, "_stall_done"}, W'(bus.stallreq), W'(0));
    bus.ack = 1'b1; bus.start = 1'b0;
    @(posedge clk); #1;
    bus.ack = 1'b0;
    check({name, "_ready_after_ack"}, W'(bus.result_ready), W'(0));
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return W'(1);
      2: return '1;
      3: return 32'h8000_0000;
      4: return W'($urandom_range(0, 20));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int lat;
    rst = 1'b1;
    bus.annul = 1'b0; bus.start = 1'b0; bus.signed_div = 1'b0;
    bus.dividend = '0; bus.divisor = '0; bus.ack = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("reset_ready", W'(bus.result_ready), W'(0));
    check("reset_q", bus.quotient, '0);

    do_div("divu_100_7",   1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         LAT);
    do_div("div_m7_2",     1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, LAT);
    do_div("div_7_m2",     1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         LAT);
    do_div("div_min_m1",   1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         LAT);
    do_div("divu_max_1",   1'b0, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0,         LAT);
    do_div("div_by_zero",  1'b0, 32'h0000_1234, 32'd0,         32'hFFFF_FFFF, 32'h0000_1234, 1);

    // annul while the iteration counter sits at 10
    @(posedge clk); #1;
    drive_op(1'b0, 32'd1000, 32'd3);
    repeat (11) @(posedge clk);
    #1;
    bus.annul = 1'b1;
    @(posedge clk); #1;
    bus.annul = 1'b0; bus.start = 1'b0;
    check("annul_ready", W'(bus.result_ready), W'(0));
    repeat (40) @(posedge clk);
    #1;
    check("annul_still_idle", W'(bus.result_ready), W'(0));
    do_div("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, LAT);

    // back-to-back: new op presented in the ack cycle with start held high
    @(posedge clk); #1;
    drive_op(1'b0, 32'd50, 32'd7);
    wait_ready(lat);
    check("b2b_first_q", bus.quotient, 32'd7);
    check("b2b_first_r", bus.remainder, 32'd1);
    bus.ack = 1'b1;
    drive_op(1'b0, 32'd83, 32'd9);
    @(posedge clk); #1;
    bus.ack = 1'b0;
    check("b2b_gap", W'(bus.result_ready), W'(0));
    drive_op(1'b0, 32'd83, 32'd9);
    wait_ready(lat);
    check("b2b_second_latency", W'(lat), W'(LAT));
    check("b2b_second_q", bus.quotient, 32'd9);
    check("b2b_second_r", bus.remainder, 32'd2);
    bus.ack = 1'b1; bus.start = 1'b0;
    @(posedge clk); #1;
    bus.ack = 1'b0;

    // synchronous reset in the middle of an operation
    drive_op(1'b1, 32'hFFFF_FF00, 32'd5);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_stallreq", W'(bus.stallreq), W'(0));
    @(posedge clk); #1;
    rst = 1'b0; bus.start = 1'b0;
    check("rst_ready", W'(bus.result_ready), W'(0));
    check("rst_q", bus.quotient, '0);
    check("rst_r", bus.remainder, '0);

    // random traffic: every cycle checked by the model comparison
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      rst            = ($urandom_range(0, 299) == 0);
      bus.annul      = ($urandom_range(0, 49) == 0);
      bus.start      = ($urandom_range(0, 9) != 0);
      bus.ack        = ($urandom_range(0, 2) == 0);
      bus.signed_div = 1'($urandom);
      bus.dividend   = pick();
      bus.divisor    = pick();
    end
    @(posedge clk); #1;
    rst = 1'b0; bus.annul = 1'b0; bus.start = 1'b0; bus.ack = 1'b0;
    @(negedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
